// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers and the
// processor status encoding used by the writeback / PC-update stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NUM_REGS = 15;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

endpackage

// File: rtl/wb_pc_update_if.sv
// Bundle of the retiring-instruction fields, decode read ports and the
// architectural state outputs of the writeback / PC-update stage.
interface wb_pc_update_if;
  import y86_pkg::*;

  logic [3:0]  in_code;
  logic        cnd;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic [63:0] val_p;
  logic [63:0] val_c;
  logic        imem_error;
  logic        instr_valid;
  logic        bad_mem2;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [63:0] val_a_rd;
  logic [63:0] val_b_rd;
  logic [63:0] pc;
  stat_t       stat;
  logic [31:0] retired_cnt;

  // Upstream pipeline / decode side.
  modport master (
    output in_code, cnd, r_a, r_b, val_e, val_m, val_p, val_c,
           imem_error, instr_valid, bad_mem2, src_a, src_b,
    input  val_a_rd, val_b_rd, pc, stat, retired_cnt
  );

  // Writeback stage side.
  modport slave (
    input  in_code, cnd, r_a, r_b, val_e, val_m, val_p, val_c,
           imem_error, instr_valid, bad_mem2, src_a, src_b,
    output val_a_rd, val_b_rd, pc, stat, retired_cnt
  );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86-64 register file: two asynchronous read ports without write
// bypass, two write ports (E then M, so M wins on a shared destination).
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic        we,
  input  logic [3:0]  dst_e,
  input  logic [63:0] data_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] data_m
);

  logic [63:0] regs [NUM_REGS];

  assign val_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? 64'd0 : regs[src_b];

  // NOTE: the array is reset on purpose -- every register is architectural
  // state with a defined power-on value, so it cannot map to a plain RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 64'd0;
      regs[RRSP] <= RSP_INIT;
    end else if (we) begin
      // NOTE: non-blocking writes; the later M assignment overrides E when
      // both target the same register, which gives popq %rsp its value.
      if (dst_e != RNONE) regs[dst_e] <= data_e;
      if (dst_m != RNONE) regs[dst_m] <= data_m;
    end
  end

endmodule

// File: rtl/wb_pc_update.sv
// SEQ Y86-64 writeback and PC-update stage: destination selection, next-PC
// mux, sticky status FSM and retired-instruction counter around the regfile.
module wb_pc_update
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input logic          clock,
  input logic          reset,
  wb_pc_update_if.slave bus
);

  logic [63:0] pc_q;
  stat_t       stat_q;
  logic [31:0] cnt_q;

  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] next_pc;
  stat_t       insn_stat;
  stat_t       stat_next;
  logic        commit;

  // Destination and next-PC selection for the retiring instruction.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    dst_e   = RNONE;
    dst_m   = RNONE;
    next_pc = bus.val_p;
    case (bus.in_code)
      IRRMOVQ:                     dst_e = bus.cnd ? bus.r_b : RNONE;
      IIRMOVQ, IOPQ:               dst_e = bus.r_b;
      ICALL, IRET, IPUSHQ, IPOPQ:  dst_e = RRSP;
      default:                     dst_e = RNONE;
    endcase
    if (bus.in_code == IMRMOVQ || bus.in_code == IPOPQ) dst_m = bus.r_a;
    case (bus.in_code)
      ICALL:   next_pc = bus.val_c;
      IJXX:    next_pc = bus.cnd ? bus.val_c : bus.val_p;
      IRET:    next_pc = bus.val_m;
      default: next_pc = bus.val_p;
    endcase
  end

  // Status FSM: RUN while AOK, any other status is absorbing until reset.
  always_comb begin
    insn_stat = STAT_AOK;
    stat_next = stat_q;
    commit    = 1'b0;
    if (bus.imem_error || bus.bad_mem2) insn_stat = STAT_ADR;
    else if (!bus.instr_valid)          insn_stat = STAT_INS;
    else if (bus.in_code == IHALT)      insn_stat = STAT_HLT;
    if (stat_q == STAT_AOK) begin
      stat_next = insn_stat;
      commit    = (insn_stat == STAT_AOK);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      stat_q <= STAT_AOK;
      cnt_q  <= 32'd0;
    end else begin
      stat_q <= stat_next;
      if (commit) begin
        pc_q  <= next_pc;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  y86_regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .src_a  (bus.src_a),
    .src_b  (bus.src_b),
    .val_a  (bus.val_a_rd),
    .val_b  (bus.val_b_rd),
    .we     (commit),
    .dst_e  (dst_e),
    .data_e (bus.val_e),
    .dst_m  (dst_m),
    .data_m (bus.val_m)
  );

  assign bus.pc          = pc_q;
  assign bus.stat        = stat_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_pc_update.sv
// Self-checking bench for wb_pc_update: directed vector table, hand-written
// fault/halt/reset sequences and a randomized run against a reference model.
module tb_wb_pc_update;
  import y86_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h100;
  localparam logic [63:0] RSP_INIT = 64'h200;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_pc_update_if bus ();

  wb_pc_update #(.RESET_PC(RESET_PC), .RSP_INIT(RSP_INIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model of architectural state.
  logic [63:0] m_regs [15];
  logic [63:0] m_pc;
  int          m_stat;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_regs[4] = RSP_INIT;
    m_pc   = RESET_PC;
    m_stat = 1;
    m_cnt  = 32'd0;
  endtask

  // Applies the currently driven instruction to the model (one clock edge).
  task automatic model_step();
    int s;
    int de, dm;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_stat != 1) return;
    if (bus.imem_error || bus.bad_mem2) s = 3;
    else if (!bus.instr_valid)          s = 4;
    else if (bus.in_code == 0)          s = 2;
    else                                s = 1;
    m_stat = s;
    if (s != 1) return;
    de = 15; dm = 15;
    case (int'(bus.in_code))
      2:             if (bus.cnd) de = int'(bus.r_b);
      3, 6:          de = int'(bus.r_b);
      8, 9, 10, 11:  de = 4;
      default:       de = 15;
    endcase
    if (bus.in_code == 5 || bus.in_code == 11) dm = int'(bus.r_a);
    if (de != 15) m_regs[de] = bus.val_e;
    if (dm != 15) m_regs[dm] = bus.val_m;
    if (bus.in_code == 8 || (bus.in_code == 7 && bus.cnd)) m_pc = bus.val_c;
    else if (bus.in_code == 9)                              m_pc = bus.val_m;
    else                                                    m_pc = bus.val_p;
    m_cnt = m_cnt + 1;
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : m_regs[r];
  endfunction

  task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [63:0] vp, input logic [63:0] vc, input logic ie,
                       input logic iv, input logic bm);
    bus.in_code = ic; bus.cnd = c; bus.r_a = ra; bus.r_b = rb;
    bus.val_e = ve; bus.val_m = vm; bus.val_p = vp; bus.val_c = vc;
    bus.imem_error = ie; bus.instr_valid = iv; bus.bad_mem2 = bm;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},   bus.pc, m_pc);
    check({tag, ".stat"}, 64'(bus.stat), 64'(m_stat));
    check({tag, ".cnt"},  64'(bus.retired_cnt), 64'(m_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  ic;
    logic        c;
    logic [3:0]  ra, rb;
    logic [63:0] ve, vm, vp, vc;
    logic        ie, iv, bm;
    logic [63:0] e_pc;
    int          e_stat;
    logic [31:0] e_cnt;
    logic [3:0]  chk_reg;
    logic [63:0] e_reg;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset = 1'b1;
    drive(INOP, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 1, 0);
    bus.src_a = 4'hF; bus.src_b = 4'hF;

    //            ic       c  ra  rb  val_e    val_m     val_p    val_c    ie iv bm  pc       st cnt reg val
    vecs[0]  = '{IIRMOVQ, 0, 15, 2, 64'h55,  64'h0,    64'h10A, 64'h0,   0, 1, 0, 64'h10A, 1, 1, 2, 64'h55};
    vecs[1]  = '{IPOPQ,   0, 4,  15,64'h208, 64'hDEAD, 64'h10C, 64'h0,   0, 1, 0, 64'h10C, 1, 2, 4, 64'hDEAD};
    vecs[2]  = '{IRRMOVQ, 0, 1,  3, 64'h77,  64'h0,    64'h10E, 64'h0,   0, 1, 0, 64'h10E, 1, 3, 3, 64'h0};
    vecs[3]  = '{ICALL,   0, 15, 15,64'h1F8, 64'h0,    64'h117, 64'h40,  0, 1, 0, 64'h40,  1, 4, 4, 64'h1F8};
    vecs[4]  = '{IRET,    0, 15, 15,64'h200, 64'h114,  64'h41,  64'h0,   0, 1, 0, 64'h114, 1, 5, 4, 64'h200};
    vecs[5]  = '{IJXX,    0, 15, 15,64'h0,   64'h0,    64'h11D, 64'h300, 0, 1, 0, 64'h11D, 1, 6, 4, 64'h200};
    vecs[6]  = '{IJXX,    1, 15, 15,64'h0,   64'h0,    64'h126, 64'h300, 0, 1, 0, 64'h300, 1, 7, 2, 64'h55};
    vecs[7]  = '{IRRMOVQ, 1, 1,  3, 64'h77,  64'h0,    64'h302, 64'h0,   0, 1, 0, 64'h302, 1, 8, 3, 64'h77};
    vecs[8]  = '{IOPQ,    0, 1,  5, 64'h9,   64'h0,    64'h304, 64'h0,   0, 1, 0, 64'h304, 1, 9, 5, 64'h9};
    vecs[9]  = '{IMRMOVQ, 0, 6,  15,64'h0,   64'hAB,   64'h30E, 64'h0,   0, 1, 1, 64'h304, 3, 9, 6, 64'h0};
    vecs[10] = '{IIRMOVQ, 0, 15, 2, 64'h99,  64'h0,    64'h30E, 64'h0,   0, 1, 0, 64'h304, 3, 9, 2, 64'h55};

    // Reset state.
    tick();
    reset = 1'b0;
    bus.src_a = 4'd4; bus.src_b = 4'hF;
    #1;
    check("rst.pc",   bus.pc, 64'h100);
    check("rst.stat", 64'(bus.stat), 64'd1);
    check("rst.cnt",  64'(bus.retired_cnt), 64'd0);
    check("rst.rsp",  bus.val_a_rd, 64'h200);
    check("rst.rnone", bus.val_b_rd, 64'd0);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ic, vecs[i].c, vecs[i].ra, vecs[i].rb, vecs[i].ve, vecs[i].vm,
            vecs[i].vp, vecs[i].vc, vecs[i].ie, vecs[i].iv, vecs[i].bm);
      if (i == 0) begin
        bus.src_a = 4'd2;
        #1;
        check("same_cycle_old", bus.val_a_rd, 64'd0);
      end
      tick();
      bus.src_b = vecs[i].chk_reg;
      #1;
      check($sformatf("vec%0d.pc", i),   bus.pc, vecs[i].e_pc);
      check($sformatf("vec%0d.stat", i), 64'(bus.stat), 64'(vecs[i].e_stat));
      check($sformatf("vec%0d.cnt", i),  64'(bus.retired_cnt), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d.reg", i),  bus.val_b_rd, vecs[i].e_reg);
    end

    // Simultaneous imem_error and illegal icode: ADR has priority.
    drive(INOP, 0, 15, 15, 0, 0, 64'h102, 0, 0, 1, 0);
    do_reset();
    drive(IIRMOVQ, 0, 15, 1, 64'h11, 0, 64'h10A, 0, 1, 0, 0);
    tick();
    check_state("adr_ins");
    check("adr_ins.stat_abs", 64'(bus.stat), 64'd3);

    // Illegal instruction alone gives INS.
    do_reset();
    drive(IIRMOVQ, 0, 15, 1, 64'h11, 0, 64'h10A, 0, 0, 0, 0);
    tick();
    check("ins.stat", 64'(bus.stat), 64'd4);
    check_state("ins");

    // Glitch on bad_mem2 between edges has no effect.
    do_reset();
    drive(IIRMOVQ, 0, 15, 1, 64'h33, 0, 64'h10A, 0, 0, 1, 1);
    #2 bus.bad_mem2 = 1'b0;
    tick();
    bus.src_a = 4'd1;
    #1;
    check("glitch.stat", 64'(bus.stat), 64'd1);
    check("glitch.reg1", bus.val_a_rd, 64'h33);
    check_state("glitch");

    // Halt is sticky; reset with an instruction present discards it.
    drive(IHALT, 0, 15, 15, 0, 0, 64'h10B, 0, 0, 1, 0);
    tick();
    check("halt.stat", 64'(bus.stat), 64'd2);
    drive(IIRMOVQ, 0, 15, 7, 64'h77, 0, 64'h200, 0, 0, 1, 0);
    tick();
    check("halt.sticky", 64'(bus.stat), 64'd2);
    check_state("halt");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.src_a = 4'd7; bus.src_b = 4'd1;
    #1;
    check("rst2.pc", bus.pc, 64'h100);
    check("rst2.stat", 64'(bus.stat), 64'd1);
    check("rst2.cnt", 64'(bus.retired_cnt), 64'd0);
    check("rst2.reg7", bus.val_a_rd, 64'd0);
    check("rst2.reg1", bus.val_b_rd, 64'd0);
    tick();
    bus.src_a = 4'd7;
    #1;
    check("after_rst.reg7", bus.val_a_rd, 64'h77);
    check("after_rst.pc", bus.pc, 64'h200);
    check("after_rst.cnt", 64'(bus.retired_cnt), 64'd1);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ic;
      ic = (($urandom % 40) == 0) ? IHALT : 4'($urandom_range(1, 11));
      drive(ic, 1'($urandom), 4'($urandom), 4'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            (($urandom % 50) == 0), (($urandom % 50) != 0), (($urandom % 50) == 0));
      reset = (m_stat != 1) ? (($urandom % 4) == 0) : (($urandom % 80) == 0);
      bus.src_a = 4'($urandom); bus.src_b = 4'($urandom);
      #1;
      check("rnd.pre_a", bus.val_a_rd, m_read(bus.src_a));
      tick();
      reset = 1'b0;
      #1;
      check("rnd.post_a", bus.val_a_rd, m_read(bus.src_a));
      check("rnd.post_b", bus.val_b_rd, m_read(bus.src_b));
      check_state("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
